// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared definitions for the RAM loader.
//   - FSM state encoding and its width
//   - default data width / depth used by the interface and top
package ram_loader_pkg;

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: stream-in handshake, RAM port and status of the loader.
//   master : loader side (drives in_ready, mem_*, busy, done, error)
//   slave  : host/RAM side (drives start, in_valid, in_data, mem_rdata)
interface ram_loader_if
   import ram_loader_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
);
   logic                 start;
   logic                 in_valid;
   logic [WIDTH-1:0]     in_data;
   logic                 in_ready;
   logic                 mem_write;
   logic [DEPTH_LOG-1:0] mem_address;
   logic [WIDTH-1:0]     mem_wdata;
   logic [WIDTH-1:0]     mem_rdata;
   logic                 busy;
   logic                 done;
   logic                 error;

   modport master (
      input  start, in_valid, in_data, mem_rdata,
      output in_ready, mem_write, mem_address, mem_wdata, busy, done, error
   );

   modport slave (
      output start, in_valid, in_data, mem_rdata,
      input  in_ready, mem_write, mem_address, mem_wdata, busy, done, error
   );

endinterface

// File: rtl/ram_loader_byte_checksum.sv
// byte_checksum: modular (mod 2^WIDTH) accumulator with synchronous clear
// and enable. Only needed by the readback check, so it exists only when
// RAM_LOADER_VERIFY_EN is defined.
//   clk, reset : clock, async active-high reset
//   clr        : zero the sum (wins over en)
//   en         : add din into the sum
//   din        : value to accumulate
//   sum        : current sum
`ifdef RAM_LOADER_VERIFY_EN
module byte_checksum #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sum
);
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;

   always_comb begin
      sum_d = sum_q;
      if (clr)
         sum_d = '0;
      else if (en)
         sum_d = sum_q + din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end

   assign sum = sum_q;

endmodule
`endif

// File: rtl/ram_loader.sv
// ram_loader: fills a RAM from a valid/ready byte stream, then (optionally)
// reads it back and compares checksums.
//   clk, reset : clock, async active-high reset
//   bus        : ram_loader_if.master (stream in, RAM port, busy/done/error)
// Optional feature: RAM_LOADER_VERIFY_EN adds the VERIFY readback state and
// checksum compare; without it LOAD goes straight to DONE and error is 0.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   ram_loader_if.master  bus
);
   state_t               state_q, state_d;
   logic [DEPTH_LOG-1:0] addr_q, addr_d;
   logic                 addr_last;

   assign addr_last = (addr_q == DEPTH_LOG'(DEPTH - 1));

`ifdef RAM_LOADER_VERIFY_EN
   logic             sum_clr;
   logic             load_en;
   logic             verify_en;
   logic [WIDTH-1:0] load_sum;
   logic [WIDTH-1:0] verify_sum;
   logic [WIDTH-1:0] verify_total_c;

   byte_checksum #(.WIDTH(WIDTH)) u_load_sum (
      .clk   (clk),
      .reset (reset),
      .clr   (sum_clr),
      .en    (load_en),
      .din   (bus.in_data),
      .sum   (load_sum)
   );

   byte_checksum #(.WIDTH(WIDTH)) u_verify_sum (
      .clk   (clk),
      .reset (reset),
      .clr   (sum_clr),
      .en    (verify_en),
      .din   (bus.mem_rdata),
      .sum   (verify_sum)
   );

   // Final readback sum must include the word at the last address.
   assign verify_total_c = verify_sum + bus.mem_rdata;
`endif

   // State and address registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next state, next address, checksum controls
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
`ifdef RAM_LOADER_VERIFY_EN
      sum_clr   = 1'b0;
      load_en   = 1'b0;
      verify_en = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               addr_d  = '0;
`ifdef RAM_LOADER_VERIFY_EN
               sum_clr = 1'b1;
`endif
            end
         end
         ST_LOAD: begin
            // in_ready is 1 here, so in_valid alone is the handshake
            if (bus.in_valid) begin
`ifdef RAM_LOADER_VERIFY_EN
               load_en = 1'b1;
`endif
               if (addr_last) begin
                  addr_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
                  state_d = ST_VERIFY;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  addr_d = addr_q + DEPTH_LOG'(1);
               end
            end
         end
`ifdef RAM_LOADER_VERIFY_EN
         ST_VERIFY: begin
            verify_en = 1'b1;
            if (addr_last) begin
               addr_d  = '0;
               state_d = (verify_total_c == load_sum) ? ST_DONE : ST_ERROR;
            end else begin
               addr_d = addr_q + DEPTH_LOG'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Outputs decoded from state; write path is zero-latency from in_valid
   always_comb begin
      bus.in_ready    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = addr_q;
      bus.mem_wdata   = bus.in_data;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.error       = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            bus.in_ready  = 1'b1;
            bus.mem_write = bus.in_valid;
            bus.busy      = 1'b1;
         end
`ifdef RAM_LOADER_VERIFY_EN
         ST_VERIFY: bus.busy  = 1'b1;
         ST_ERROR:  bus.error = 1'b1;
`endif
         ST_DONE:   bus.done  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: self-checking bench for ram_loader with a behavioural RAM,
// a write scoreboard, a control-edge vector table and multi-cycle sequences.
module tb_ram_loader;
   localparam int unsigned W = 8;
   localparam int unsigned D = 16;
`ifdef RAM_LOADER_VERIFY_EN
   localparam int EXP_CONT = 33;
   localparam int EXP_GAP  = 48;
`else
   localparam int EXP_CONT = 17;
   localparam int EXP_GAP  = 32;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic corrupt = 1'b0;

   ram_loader_if #(.WIDTH(W), .DEPTH(D)) bus ();

   ram_loader #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endfunction

   // Behavioural RAM with optional bit-0 corruption of word 5 on readback
   logic [W-1:0] ram     [D];
   logic [W-1:0] exp_ram [D];
   always @(posedge clk) if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
   assign bus.mem_rdata = ram[bus.mem_address] ^ ((corrupt && bus.mem_address == 4'd5) ? 8'h01 : 8'h00);

   // Write scoreboard
   typedef struct packed { logic [3:0] addr; logic [7:0] data; } wr_t;
   wr_t sb_q [$];

   always @(negedge clk) begin
      if (!reset && bus.mem_write === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", 32'(bus.mem_address), 32'hFFFF);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            check("wr_addr", 32'(bus.mem_address), 32'(e.addr));
            check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
         end
      end
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic push_write(input logic [3:0] a, input logic [7:0] d);
      sb_q.push_back('{addr: a, data: d});
      exp_ram[a] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      step_clk();
      reset = 1'b0;
   endtask

   task automatic check_ram();
      int bad = 0;
      for (int i = 0; i < int'(D); i++) if (ram[i] !== exp_ram[i]) bad++;
      check("ram_contents", 32'(bad), 0);
      check("sb_drained", 32'(sb_q.size()), 0);
   endtask

   // Start a load, feed n_words words base+stp*n (gapped: idle on even cycles),
   // and for a full load wait for done/error. cyc = cycles since start edge.
   task automatic run_load(input bit gapped, input logic [7:0] base, input logic [7:0] stp,
                           input int n_words, output int cyc);
      int n = 0;
      bus.start = 1'b1;
      bus.in_valid = 1'b0;
      step_clk();
      bus.start = 1'b0;
      cyc = 1;
      while (n < n_words && cyc < 200) begin
         if (gapped && (cyc % 2 == 0)) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 8'(int'(stp) * n);
            push_write(4'(n), bus.in_data);
            n++;
         end
         step_clk();
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (n_words == int'(D))
         while (!(bus.done || bus.error) && cyc < 200) begin
            step_clk();
            cyc++;
         end
      if (cyc >= 200) check("load_timeout", 1, 0);
   endtask

   typedef struct {
      logic       start;
      logic       valid;
      logic [7:0] data;
      logic       e_ready;
      logic       e_write;
      logic       e_busy;
      logic       e_done;
      logic [3:0] e_addr;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // Reset state
      step_clk();
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_error", 32'(bus.error), 0);
      check("rst_write", 32'(bus.mem_write), 0);
      check("rst_addr", 32'(bus.mem_address), 0);
      reset = 1'b0;
      step_clk();

      // Control-edge table: start, gaps, start ignored during LOAD
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[3] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
      vecs[5] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
      for (int i = 0; i < 7; i++) begin
         bus.start    = vecs[i].start;
         bus.in_valid = vecs[i].valid;
         bus.in_data  = vecs[i].data;
         if (vecs[i].e_write) push_write(vecs[i].e_addr, vecs[i].data);
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
         check($sformatf("vec%0d_write", i), 32'(bus.mem_write), 32'(vecs[i].e_write));
         check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
         check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
         check($sformatf("vec%0d_addr", i), 32'(bus.mem_address), 32'(vecs[i].e_addr));
         step_clk();
      end
      do_reset();

      // Continuous stream 0x00..0x0F
      run_load(1'b0, 8'h00, 8'h01, 16, cyc);
      check("cont_cycles", 32'(cyc), 32'(EXP_CONT));
      check("cont_done", 32'(bus.done), 1);
      check("cont_error", 32'(bus.error), 0);
      check("cont_busy", 32'(bus.busy), 0);
      check_ram();

      // done holds without start
      repeat (3) step_clk();
      check("done_hold", 32'(bus.done), 1);

      // start in DONE clears done and restarts at address 0
      bus.start = 1'b1;
      step_clk();
      bus.start = 1'b0;
      check("restart_done", 32'(bus.done), 0);
      check("restart_busy", 32'(bus.busy), 1);
      check("restart_ready", 32'(bus.in_ready), 1);
      check("restart_addr", 32'(bus.mem_address), 0);
      do_reset();

      // Gapped stream
      run_load(1'b1, 8'hA0, 8'h03, 16, cyc);
      check("gap_cycles", 32'(cyc), 32'(EXP_GAP));
      check("gap_done", 32'(bus.done), 1);
      check_ram();

      // Reset at address 7 mid-LOAD, then reload
      run_load(1'b0, 8'h50, 8'h01, 7, cyc);
      check("mid_addr", 32'(bus.mem_address), 7);
      reset = 1'b1;
      step_clk();
      check("mid_rst_ready", 32'(bus.in_ready), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_addr", 32'(bus.mem_address), 0);
      reset = 1'b0;
      step_clk();
      run_load(1'b0, 8'hC0, 8'h05, 16, cyc);
      check("reload_done", 32'(bus.done), 1);
      check("reload_cycles", 32'(cyc), 32'(EXP_CONT));
      check_ram();

      // All-0xFF stream
      run_load(1'b0, 8'hFF, 8'h00, 16, cyc);
      check("ff_cycles", 32'(cyc), 32'(EXP_CONT));
      check("ff_done", 32'(bus.done), 1);
      check("ff_error", 32'(bus.error), 0);
      check_ram();

`ifdef RAM_LOADER_VERIFY_EN
      // Readback corruption of word 5
      corrupt = 1'b1;
      run_load(1'b0, 8'h10, 8'h07, 16, cyc);
      check("corr_cycles", 32'(cyc), 33);
      check("corr_error", 32'(bus.error), 1);
      check("corr_done", 32'(bus.done), 0);
      check("corr_busy", 32'(bus.busy), 0);
      corrupt = 1'b0;
      check_ram();
      repeat (2) step_clk();
      check("error_hold", 32'(bus.error), 1);
      bus.start = 1'b1;
      step_clk();
      bus.start = 1'b0;
      check("err_restart_error", 32'(bus.error), 0);
      check("err_restart_busy", 32'(bus.busy), 1);
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_loader.md
# ram_loader

Bus-initiator block that fills the 8-bit computer's RAM from a byte stream before program execution. It accepts DEPTH words over a valid/ready handshake and drives the RAM's write, address and data-in pins. It then optionally reads the whole RAM back and compares checksums. It sits between the host/program source and the RAM, and owns the RAM port while busy.

## Interface
- WIDTH, 8, data word width; must match the RAM.
- DEPTH, 16, number of RAM words to load.
- DEPTH_LOG, $clog2(DEPTH), address width.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  reset; one clock, reset is asynchronous and active-high.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- in_valid  in  1  in_data holds a word.
- in_data  in  WIDTH  word to store.
- in_ready  out  1  loader accepts a word this cycle.
- mem_write  out  1  to RAM write.
- mem_address  out  DEPTH_LOG  to RAM address.
- mem_wdata  out  WIDTH  to RAM data_in.
- mem_rdata  in  WIDTH  from RAM data_out (combinational read of mem_address).
- busy  out  1  in LOAD or VERIFY.
- done  out  1  load completed successfully; level signal.
- error  out  1  verify mismatch; level signal.

## Operation
- States: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR with start=1: go to LOAD; addr<=0, load_sum<=0, verify_sum<=0, done<=0, error<=0.
- In any other state, start is ignored.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready; it writes in_data to RAM at addr on that edge (mem_write=in_valid, mem_wdata=in_data).
  - On each handshake: load_sum<=load_sum+in_data (mod 2^WIDTH), addr<=addr+1.
  - No handshake: no write, addr holds.
- Handshake at addr=DEPTH-1: addr<=0, then go to VERIFY (macro on) or DONE (macro off).
- VERIFY:
  - mem_write=0; each cycle verify_sum<=verify_sum+mem_rdata, addr++.
  - At addr=DEPTH-1 the final sum includes that word. Go to DONE if it equals load_sum, else ERROR.
- mem_address=addr in all states. mem_write=0 outside LOAD. in_ready=0 outside LOAD.
- busy=1 in LOAD and VERIFY. done=1 only in DONE; error=1 only in ERROR.
- Reset (any time, including mid-load): state IDLE, addr 0, sums 0, all outputs 0. Partially written RAM contents are left as-is.

## Timing
- in_ready and mem_write are combinational from state/in_valid; write latency 0 (same edge as handshake).
- LOAD lasts DEPTH handshakes; valid gaps stretch it cycle-for-cycle.
- VERIFY lasts exactly DEPTH cycles.
- done/error assert on the edge after the last VERIFY cycle (macro on) or the last handshake edge (macro off).
- done/error hold until start or reset.

## Configuration
- RAM_LOADER_VERIFY_EN defined:
  - VERIFY state, verify_sum and compare logic present.
  - error reachable.
- Not defined:
  - VERIFY and the sum registers are removed; LOAD goes straight to DONE.
  - error tied to 0; mem_rdata unused.

## Structure
- Shared package/header ram_loader_pkg holds the state encodings (IDLE=0, LOAD=1, VERIFY=2, DONE=3, ERROR=4) and the state width constant.
- Sub-module byte_checksum (WIDTH-parameterised modular accumulator with clear and enable) is instantiated for load_sum and verify_sum.

## Test plan
- Continuous load: start, stream 0x00..0x0F with in_valid=1 -> 16 writes to addresses 0..15, load_sum=0x78, VERIFY 16 cycles; done=1 on cycle 33 after start; RAM matches.
- Gapped stream: in_valid low every other cycle -> writes only on handshakes, addresses still 0..15 in order, done=1.
- Corruption: RAM model flips bit 0 of word 5 during VERIFY -> error=1, done=0, busy=0.
- Reset at address 7 mid-LOAD -> next cycle in_ready=0, busy=0, mem_address=0; a subsequent start reloads from address 0.
- Control edges:
  - start during LOAD is ignored; addr continues.
  - start in DONE clears done and restarts at address 0.
- Macro undefined: stream 0xFF x16 -> done=1 one edge after 16th handshake, error stays 0, no VERIFY cycles.
